// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and constants for the UART transmit serializer.
// FSM encoding, line-level bit values, parity selects and per-frame config.
package uart_tx_serializer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    // Parity options latched when a byte moves into the shift register
    typedef struct packed {
        logic par_en;
        logic par_typ;
    } frame_cfg_t;

    function automatic logic parity_bit(input logic xor_all, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~xor_all : xor_all;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte-side handshake, frame config and serial line outputs of the TX serializer.
// master drives bytes and config; slave is the serializer.
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    import uart_tx_serializer_pkg::*;

    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  data_ready;
    logic                  par_en;
    logic                  par_typ;
    logic [PRESCALE_W-1:0] prescale;
    logic                  tx_out;
    logic                  busy;

    modport master (
        output p_data, data_valid, par_en, par_typ, prescale,
        input  data_ready, tx_out, busy
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ, prescale,
        output data_ready, tx_out, busy
    );

endinterface

// File: rtl/uart_tx_serializer_parity.sv
// Combinational parity over DATA_WIDTH bits: even -> ^data, odd -> ~^data.
module uart_parity_calc
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    assign parity = parity_bit(^data, par_typ);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART TX engine: 1-entry holding register feeding a start/data/parity/stop serializer.
// Define UART_TX_PRESCALE_EN to stretch each bit to PRESCALE clocks (0 or 1 acts as 1).
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_serializer_if.slave    bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  hold_full_q;
    frame_cfg_t            cfg_q;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  load;
    logic                  accept;
    logic                  bit_tick;
    logic                  par_bit;

    assign accept          = bus.data_valid & ~hold_full_q;
    assign bus.data_ready  = ~hold_full_q;
    assign bus.tx_out      = tx_q;
    assign bus.busy        = (state_q != IDLE);

`ifdef UART_TX_PRESCALE_EN
    logic [PRESCALE_W-1:0] baud_q;
    logic [PRESCALE_W-1:0] baud_last;

    assign baud_last = (bus.prescale > PRESCALE_W'(1)) ? bus.prescale - PRESCALE_W'(1) : '0;
    // >= keeps a mid-bit PRESCALE decrease from wrapping the counter
    assign bit_tick  = (baud_q >= baud_last);

    always_ff @(posedge clk) begin
        if (!rst)
            baud_q <= '0;
        else if (state_q == IDLE || bit_tick)
            baud_q <= '0;
        else
            baud_q <= baud_q + PRESCALE_W'(1);
    end
`else
    logic unused_prescale;
    assign unused_prescale = ^bus.prescale;
    assign bit_tick        = 1'b1;
`endif

    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data    (shift_q),
        .par_typ (cfg_q.par_typ),
        .parity  (par_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_q        <= STOP_BIT;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            shift_q     <= '0;
            cfg_q       <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            if (accept) begin
                hold_q      <= bus.p_data;
                hold_full_q <= 1'b1;
            end else if (load) begin
                hold_full_q <= 1'b0;
            end
            if (load) begin
                shift_q <= hold_q;
                cfg_q   <= '{par_en: bus.par_en, par_typ: bus.par_typ};
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d = START;
                    load    = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1))
                        state_d = cfg_q.par_en ? PARITY : STOP;
                    else
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bit_tick)
                    state_d = STOP;
            end
            STOP: begin
                // a waiting byte starts immediately, no idle bit between frames
                if (bit_tick) begin
                    if (hold_full_q) begin
                        state_d = START;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // line register follows the state being entered on this edge
        tx_d = STOP_BIT;
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_q[bit_cnt_d];
            PARITY:  tx_d = par_bit;
            default: tx_d = STOP_BIT;
        endcase
    end

endmodule
